// File: rtl/rpi_line_capture_if.sv
// rtl/rpi_line_capture_if.sv - line-buffer bit-serial write port
// Carries the write strobe, bit index and data from the capture stage to the line buffer.
interface rpi_line_capture_if #(
    parameter int ADDR_W = 7
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/rpi_line_capture.sv
// rtl/rpi_line_capture.sv - RPi DPI single-line capture and decimation into the VGA line buffer
// Optional CAPTURE_MAJORITY_EN: store the majority of each pixel group instead of its first pixel.
module rpi_line_capture #(
    parameter int DECIM       = 4,
    parameter int LINE_BITS   = 90,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                rpi_pixel_clock,
    input  logic                rpi_DEN,
    input  logic                b_in,
    input  logic                arm,
    rpi_line_capture_if.master  wr,
    output logic                busy,
    output logic                line_done,
    output logic [ADDR_W-1:0]   bit_count,
    output logic                overflow
);
    localparam int SUB_W = $clog2(DECIM);
    localparam logic [ADDR_W-1:0] LINE_LIM = ADDR_W'(LINE_BITS);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_LOW = 3'd1;
    localparam logic [2:0] ST_WAIT_DEN = 3'd2;
    localparam logic [2:0] ST_CAPTURE  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // The pixel clock chain is one stage longer so the edge detector sees "prev" and "now".
    logic [SYNC_STAGES:0]   pclk_sync_q;
    logic [SYNC_STAGES-1:0] den_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;

    logic [2:0]        state_q, state_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [ADDR_W-1:0] bit_count_q, bit_count_d;
    logic              overflow_q, overflow_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_data_q, wr_data_d;
    logic              grp_write, grp_bit;
`ifdef CAPTURE_MAJORITY_EN
    localparam int CMP_W = SUB_W + 2;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DECIM - 1);
    logic [SUB_W:0] ones_q, ones_d, ones_new;
`endif

    logic pix_ev, den, pix_b;
    assign pix_ev = pclk_sync_q[SYNC_STAGES-1] & ~pclk_sync_q[SYNC_STAGES];
    assign den    = den_sync_q[SYNC_STAGES-1];
    assign pix_b  = b_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        bit_count_d = bit_count_q;
        overflow_d  = overflow_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grp_write   = 1'b0;
        grp_bit     = 1'b0;
`ifdef CAPTURE_MAJORITY_EN
        ones_d      = ones_q;
        ones_new    = ones_q + {{SUB_W{1'b0}}, pix_b};
`endif
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_WAIT_LOW;
                    sub_d       = '0;
                    bit_count_d = '0;
                    overflow_d  = 1'b0;
`ifdef CAPTURE_MAJORITY_EN
                    ones_d      = '0;
`endif
                end
            end
            ST_WAIT_LOW: begin
                if (!den) state_d = ST_WAIT_DEN;
            end
            ST_WAIT_DEN, ST_CAPTURE: begin
                if (state_q == ST_CAPTURE && !den) begin
                    state_d = ST_DONE;
`ifdef CAPTURE_MAJORITY_EN
                    if (sub_q != '0) begin
                        grp_write = 1'b1;
                        grp_bit   = ({ones_q, 1'b0} >= {2'b00, sub_q});
                    end
`endif
                end else if (den) begin
                    // DEN high without a pixel yet still opens the line, so an empty line reports done.
                    state_d = ST_CAPTURE;
                    if (pix_ev) begin
                        sub_d = sub_q + SUB_W'(1);
`ifdef CAPTURE_MAJORITY_EN
                        if (sub_q == SUB_LAST) begin
                            grp_write = 1'b1;
                            grp_bit   = ({ones_new, 1'b0} >= CMP_W'(DECIM));
                            ones_d    = '0;
                        end else begin
                            ones_d    = ones_new;
                        end
`else
                        if (sub_q == '0) begin
                            grp_write = 1'b1;
                            grp_bit   = pix_b;
                        end
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (grp_write) begin
            if (bit_count_q < LINE_LIM) begin
                wr_en_d     = 1'b1;
                wr_addr_d   = bit_count_q;
                wr_data_d   = grp_bit;
                bit_count_d = bit_count_q + ADDR_W'(1);
            end else begin
                overflow_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            pclk_sync_q <= '0;
            den_sync_q  <= '0;
            b_sync_q    <= '0;
            state_q     <= ST_IDLE;
            sub_q       <= '0;
            bit_count_q <= '0;
            overflow_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 1'b0;
`ifdef CAPTURE_MAJORITY_EN
            ones_q      <= '0;
`endif
        end else begin
            pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-1:0], rpi_pixel_clock};
            den_sync_q  <= {den_sync_q[SYNC_STAGES-2:0], rpi_DEN};
            b_sync_q    <= {b_sync_q[SYNC_STAGES-2:0], b_in};
            state_q     <= state_d;
            sub_q       <= sub_d;
            bit_count_q <= bit_count_d;
            overflow_q  <= overflow_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef CAPTURE_MAJORITY_EN
            ones_q      <= ones_d;
`endif
        end
    end

    assign wr.wr_en   = wr_en_q;
    assign wr.wr_addr = wr_addr_q;
    assign wr.wr_data = wr_data_q;
    assign busy       = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_DEN) || (state_q == ST_CAPTURE);
    assign line_done  = (state_q == ST_DONE);
    assign bit_count  = bit_count_q;
    assign overflow   = overflow_q;
endmodule
